// File: rtl/mux_sel_sequencer_pkg.sv
// Shared definitions for the pattern-playback sequencer that feeds the 7:1 bit-select mux.
// FSM encoding, pattern width and the last select index played in a pass.
package mux_sel_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int         PAT_W    = 7;
   localparam logic [2:0] SEL_LAST = 3'd6;

endpackage

// File: rtl/mux_sel_sequencer_rate_divider.sv
// Free-running rate divider: counts 0..DIV_MAX while enabled and flags the terminal count.
// tick is high for the single cycle in which the counter sits at DIV_MAX.
module rate_divider #(
   parameter int DIV_MAX = 49999999,
   parameter int DIV_W   = 26
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;
   logic             at_max;

   assign at_max = (count_q == DIV_W'(DIV_MAX));
   assign tick   = enable && at_max;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         // exact-equality wrap keeps the count inside 0..DIV_MAX
         count_d = at_max ? '0 : count_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Pattern-playback sequencer: holds a 7-bit word and steps the mux select 0..6 at the divided rate.
// All outputs come straight from flops, so the downstream mux sees glitch-free word/sel.
module mux_sel_sequencer
   import mux_sel_sequencer_pkg::*;
#(
   parameter int DIV_MAX = 49999999,
   parameter int DIV_W   = 26
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [PAT_W-1:0] data,
   input  logic             start,
   input  logic             abort,
   output logic [PAT_W-1:0] word,
   output logic [2:0]       sel,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] word_q, word_d;
   logic [2:0]       sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_clear;
   logic             div_enable;
   logic             tick;

   // Divider only runs in RUN; abort zeroes it on the same edge that leaves RUN.
   assign div_enable = (state_q == ST_RUN);
   assign div_clear  = (state_q != ST_RUN) || abort;

   rate_divider #(
      .DIV_MAX (DIV_MAX),
      .DIV_W   (DIV_W)
   ) u_rate_divider (
      .clk    (clk),
      .resetn (resetn),
      .clear  (div_clear),
      .enable (div_enable),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      sel_d   = sel_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sel_d = 3'd0;
            if (load) begin
               word_d = data;
            end
            if (start) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            busy_d = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               sel_d   = 3'd0;
               busy_d  = 1'b0;
            end else if (tick) begin
               if (sel_q == SEL_LAST) begin
                  state_d = ST_DONE;
                  sel_d   = 3'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  sel_d = sel_q + 3'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            sel_d   = 3'd0;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         sel_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign word = word_q;
   assign sel  = sel_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: a pass-position model predicts outputs per clock, a monitor compares at negedge.
module tb_mux_sel_sequencer;

   localparam int D     = 3;
   localparam int HOLD  = D + 1;
   localparam int PASSL = 7 * HOLD;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       load = 1'b0;
   logic [6:0] data = '0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [6:0] word;
   logic [2:0] sel;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [6:0] word;
      logic [2:0] sel;
      logic       busy;
      logic       done;
      logic       mux;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: mode 0=idle 1=playing 2=finished, m_pos = clocks since pass start
   int         m_mode = 0;
   int         m_pos  = 0;
   logic [6:0] m_word = '0;

   mux_sel_sequencer #(.DIV_MAX(D), .DIV_W(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .load   (load),
      .data   (data),
      .start  (start),
      .abort  (abort),
      .word   (word),
      .sel    (sel),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   task automatic model_step(input logic l, input logic [6:0] d, input logic s, input logic a);
      exp_t e;
      case (m_mode)
         0: begin
            if (l) m_word = d;
            if (s) begin
               m_mode = 1;
               m_pos  = 0;
            end
         end
         1: begin
            if (a) m_mode = 0;
            else begin
               m_pos++;
               if (m_pos == PASSL) m_mode = 2;
            end
         end
         default: m_mode = 0;
      endcase
      e.word = m_word;
      e.sel  = (m_mode == 1) ? 3'(m_pos / HOLD) : 3'd0;
      e.busy = (m_mode == 1);
      e.done = (m_mode == 2);
      e.mux  = m_word[e.sel];
      exp_q.push_back(e);
   endtask

   task automatic cycle(input logic l, input logic [6:0] d, input logic s, input logic a);
      @(negedge clk);
      load = l; data = d; start = s; abort = a;
      @(posedge clk);
      model_step(l, d, s, a);
      $display("txn t=%0t load=%0b data=%02h start=%0b abort=%0b -> exp sel=%0d busy=%0b done=%0b",
               $time, l, d, s, a, exp_q[$].sel, exp_q[$].busy, exp_q[$].done);
   endtask

   task automatic idle_until_pos(input int pos);
      int guard = 0;
      while (!(m_mode == 1 && m_pos == pos) && guard < 200) begin
         cycle(1'b0, 7'h00, 1'b0, 1'b0);
         guard++;
      end
      chk("reach_pos", 32'(m_pos), 32'(pos));
   endtask

   task automatic reset_mid();
      @(negedge clk);
      load = 1'b0; start = 1'b0; abort = 1'b0;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      exp_q.delete();
      #1;
      chk("async_rst_word", 32'(word), 32'h0);
      chk("async_rst_sel",  32'(sel),  32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_done", 32'(done), 32'h0);
      m_mode = 0; m_pos = 0; m_word = '0;
      @(negedge clk);
      @(negedge clk);
      #1 resetn = 1'b1;
   endtask

   // Monitor: one expectation per clock while out of reset
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("word", 32'(word), 32'(e.word));
            chk("sel",  32'(sel),  32'(e.sel));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("mux",  32'(word[sel]), 32'(e.mux));
         end
      end
   end

   initial begin
      #3;
      chk("reset_word", 32'(word), 32'h0);
      chk("reset_sel",  32'(sel),  32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1 resetn = 1'b1;

      // Basic pass with pattern 1011001
      cycle(1'b1, 7'b1011001, 1'b0, 1'b0);
      cycle(1'b0, 7'h00, 1'b1, 1'b0);
      repeat (32) cycle(1'b0, 7'h00, 1'b0, 1'b0);

      // load/start while running must be ignored
      cycle(1'b0, 7'h00, 1'b1, 1'b0);
      idle_until_pos(3 * HOLD + 1);
      cycle(1'b1, 7'h7F, 1'b1, 1'b0);
      repeat (32) cycle(1'b0, 7'h00, 1'b0, 1'b0);

      // abort coinciding with the sel=4 tick, then replay
      cycle(1'b0, 7'h00, 1'b1, 1'b0);
      idle_until_pos(4 * HOLD + D);
      cycle(1'b0, 7'h00, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 7'h00, 1'b0, 1'b1);
      cycle(1'b0, 7'h00, 1'b1, 1'b0);
      repeat (32) cycle(1'b0, 7'h00, 1'b0, 1'b0);

      // load and start together
      cycle(1'b1, 7'h2A, 1'b1, 1'b0);
      repeat (32) cycle(1'b0, 7'h00, 1'b0, 1'b0);

      // asynchronous reset mid-pass at sel=5
      cycle(1'b0, 7'h00, 1'b1, 1'b0);
      idle_until_pos(5 * HOLD + 1);
      reset_mid();
      repeat (4) cycle(1'b0, 7'h00, 1'b0, 1'b0);

      // start held high: back-to-back passes
      cycle(1'b1, 7'h35, 1'b0, 1'b0);
      repeat (70) cycle(1'b0, 7'h00, 1'b1, 1'b0);

      // randomized traffic
      repeat (500) begin
         cycle(($urandom_range(3) == 0), 7'($urandom_range(127)),
               ($urandom_range(2) == 0), ($urandom_range(15) == 0));
      end

      @(negedge clk);
      load = 1'b0; start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
